// File: rtl/sobel_stream_pkg.sv
// Shared types and constants for the streaming Sobel filter.
package sobel_stream_pkg;

    typedef enum logic [1:0] {
        MODE_GX   = 2'd0,
        MODE_GY   = 2'd1,
        MODE_MAG  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] MIN_DIM = 16'd3;

    // Signed width of Gx/Gy: a 4x pixel range plus sign needs three extra bits.
    function automatic int grad_width(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer indexed by column. On each accepted pixel the middle
// row entry moves to the top row and the new pixel becomes the middle row.
// Reads are combinational so they align with the pixel being accepted.
module sobel_line_buffer #(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 640,
    parameter int AW        = $clog2(MAX_WIDTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] top,
    output logic [PIX_W-1:0] mid
);

    logic [PIX_W-1:0] row_top [MAX_WIDTH];
    logic [PIX_W-1:0] row_mid [MAX_WIDTH];

    assign top = row_top[addr];
    assign mid = row_mid[addr];

    // Shift the column entry up one row when a pixel is accepted.
    always_ff @(posedge clk) begin
        if (we) begin
            row_top[addr] <= row_mid[addr];
            row_mid[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel engine: raster pixels in, one gradient per interior
// pixel out (Gx, Gy or |Gx|+|Gy|).
// Optional build macro SOBEL_THRESH_EN adds cfg_thresh and binarises mode 2.
module sobel_stream_filter
    import sobel_stream_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 640,
    parameter int OUT_W     = PIX_W + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      cfg_width,
    input  logic [15:0]      cfg_height,
    input  logic [1:0]       cfg_mode,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [OUT_W-1:0] cfg_thresh
`endif
);

    localparam int GW = grad_width(PIX_W);
    localparam int AW = $clog2(MAX_WIDTH);

    state_e           state_r, state_s;
    mode_e            mode_r;
    logic [15:0]      width_r, height_r, row_r, col_r;
    logic             busy_r, done_r, error_r;
    logic             m_valid_r, m_last_r;
    logic [OUT_W-1:0] m_data_r;
`ifdef SOBEL_THRESH_EN
    logic [OUT_W-1:0] thresh_r;
`endif

    logic [PIX_W-1:0] c0_t_r, c0_m_r, c0_b_r, c1_t_r, c1_m_r, c1_b_r;
    logic [PIX_W-1:0] top_s, mid_s;
    logic             accept_s, cfg_ok_s, last_pix_s, emit_s, go_s;
    logic [GW-1:0]    gx_s, gy_s, ax_s, ay_s;
    logic [OUT_W-1:0] mag_s, result_s;

    assign s_ready    = (state_r == ST_RUN) && (!m_valid_r || m_ready);
    assign accept_s   = s_valid && s_ready;
    assign cfg_ok_s   = (cfg_width >= MIN_DIM) && (cfg_width <= 16'(MAX_WIDTH)) &&
                        (cfg_height >= MIN_DIM) && (mode_e'(cfg_mode) != MODE_RSVD);
    assign go_s       = (state_r == ST_IDLE) && start && cfg_ok_s;
    assign last_pix_s = (row_r == height_r - 16'd1) && (col_r == width_r - 16'd1);
    assign emit_s     = accept_s && (row_r >= 16'd2) && (col_r >= 16'd2);

    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;

    sobel_line_buffer #(
        .PIX_W     (PIX_W),
        .MAX_WIDTH (MAX_WIDTH),
        .AW        (AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (accept_s),
        .addr  (col_r[AW-1:0]),
        .wdata (s_data),
        .top   (top_s),
        .mid   (mid_s)
    );

    function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return {{(GW-PIX_W){1'b0}}, p};
    endfunction

    // Gradients over the two stored window columns plus the incoming column.
    always_comb begin
        gx_s = (ext(top_s) + (ext(mid_s) << 1) + ext(s_data))
             - (ext(c0_t_r) + (ext(c0_m_r) << 1) + ext(c0_b_r));
        gy_s = (ext(c0_b_r) + (ext(c1_b_r) << 1) + ext(s_data))
             - (ext(c0_t_r) + (ext(c1_t_r) << 1) + ext(top_s));
        ax_s = gx_s[GW-1] ? (~gx_s + {{(GW-1){1'b0}}, 1'b1}) : gx_s;
        ay_s = gy_s[GW-1] ? (~gy_s + {{(GW-1){1'b0}}, 1'b1}) : gy_s;
        mag_s = OUT_W'(ax_s) + OUT_W'(ay_s);
    end

    // Select the output value for the latched mode.
    always_comb begin
        result_s = {OUT_W{1'b0}};
        case (mode_r)
            MODE_GX:  result_s = {{(OUT_W-GW){gx_s[GW-1]}}, gx_s};
            MODE_GY:  result_s = {{(OUT_W-GW){gy_s[GW-1]}}, gy_s};
`ifdef SOBEL_THRESH_EN
            MODE_MAG: result_s = (mag_s > thresh_r) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
`else
            MODE_MAG: result_s = mag_s;
`endif
            default:  result_s = {OUT_W{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (go_s) state_s = ST_RUN; else state_s = ST_IDLE;
            ST_RUN:   if (accept_s && last_pix_s) state_s = ST_DRAIN; else state_s = ST_RUN;
            ST_DRAIN: if (m_valid_r && m_ready && m_last_r) state_s = ST_DONE; else state_s = ST_DRAIN;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Registered status flags and latched configuration; error is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            width_r  <= 16'd0;
            height_r <= 16'd0;
            mode_r   <= MODE_GX;
`ifdef SOBEL_THRESH_EN
            thresh_r <= {OUT_W{1'b0}};
`endif
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            if (go_s) begin
                width_r  <= cfg_width;
                height_r <= cfg_height;
                mode_r   <= mode_e'(cfg_mode);
                error_r  <= 1'b0;
`ifdef SOBEL_THRESH_EN
                thresh_r <= cfg_thresh;
`endif
            end else if ((state_r == ST_IDLE) && start) begin
                error_r <= 1'b1;
            end
        end
    end

    // Raster row/column position of the next pixel to accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= 16'd0;
            col_r <= 16'd0;
        end else if (go_s) begin
            row_r <= 16'd0;
            col_r <= 16'd0;
        end else if (accept_s) begin
            if (col_r == width_r - 16'd1) begin
                col_r <= 16'd0;
                row_r <= row_r + 16'd1;
            end else begin
                col_r <= col_r + 16'd1;
            end
        end
    end

    // Shift the newest column into the two-column window history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_t_r <= {PIX_W{1'b0}};
            c0_m_r <= {PIX_W{1'b0}};
            c0_b_r <= {PIX_W{1'b0}};
            c1_t_r <= {PIX_W{1'b0}};
            c1_m_r <= {PIX_W{1'b0}};
            c1_b_r <= {PIX_W{1'b0}};
        end else if (accept_s) begin
            c0_t_r <= c1_t_r;
            c0_m_r <= c1_m_r;
            c0_b_r <= c1_b_r;
            c1_t_r <= top_s;
            c1_m_r <= mid_s;
            c1_b_r <= s_data;
        end
    end

    // Output register: load on an emitting accept, otherwise retire on m_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= {OUT_W{1'b0}};
        end else if (emit_s) begin
            m_valid_r <= 1'b1;
            m_last_r  <= last_pix_s;
            m_data_r  <= result_s;
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed self-checking bench for sobel_stream_filter (default build).
module tb_sobel_stream_filter;

    localparam int PIX_W     = 8;
    localparam int MAX_WIDTH = 640;
    localparam int OUT_W     = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [15:0]      cfg_width = 16'd0;
    logic [15:0]      cfg_height = 16'd0;
    logic [1:0]       cfg_mode = 2'd0;
    logic             busy, done, error;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [PIX_W-1:0] s_data = 8'd0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [OUT_W-1:0] m_data;
    logic             m_last;

    int n_cmp = 0;
    int n_err = 0;

    sobel_stream_filter #(
        .PIX_W     (PIX_W),
        .MAX_WIDTH (MAX_WIDTH),
        .OUT_W     (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_mode   (cfg_mode),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef SOBEL_THRESH_EN
        ,
        .cfg_thresh ({OUT_W{1'b0}})
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int pat, input int r, input int c);
        int v;
        case (pat)
            0:       v = c * 10;
            1:       v = r * 10;
            default: v = 200 - c * 10;
        endcase
        return 8'(v);
    endfunction

    task automatic do_start(input int w, input int h, input int mode);
        @(negedge clk);
        start      = 1'b1;
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        cfg_mode   = 2'(mode);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},    32'(busy),    32'd0);
        check_eq({tag, "_done"},    32'(done),    32'd0);
        check_eq({tag, "_mvalid"},  32'(m_valid), 32'd0);
        check_eq({tag, "_mlast"},   32'(m_last),  32'd0);
        check_eq({tag, "_sready"},  32'(s_ready), 32'd0);
        check_eq({tag, "_mdata"},   32'(m_data),  32'd0);
    endtask

    // Run a full frame; every result is expected to equal exp_val.
    task automatic run_frame(input string name, input int w, input int h, input int mode,
                             input int pat, input bit bp, input bit gaps,
                             input logic [31:0] exp_val);
        int pix, outs, n_pix, n_out, done_cnt;
        bit finished, stalled;
        logic [OUT_W-1:0] held;
        pix = 0; outs = 0; done_cnt = 0; finished = 1'b0; stalled = 1'b0; held = '0;
        n_pix = w * h;
        n_out = (w - 2) * (h - 2);
        do_start(w, h, mode);
        check_eq({name, "_busy_start"}, 32'(busy), 32'd1);
        check_eq({name, "_err_start"},  32'(error), 32'd0);
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            m_ready = bp ? (cyc % 2 == 0) : 1'b1;
            s_valid = (pix < n_pix) && (!gaps || ($urandom_range(0, 2) != 0));
            s_data  = (pix < n_pix) ? pix_val(pat, pix / w, pix % w) : 8'd0;
            #1;
            if (stalled) begin
                check_eq({name, "_stall_valid"}, 32'(m_valid), 32'd1);
                check_eq({name, "_stall_data"},  32'(m_data),  32'(held));
            end
            if (done) begin
                done_cnt++;
                finished = 1'b1;
            end
            if (s_valid && s_ready) pix++;
            if (m_valid && m_ready) begin
                check_eq($sformatf("%s_data%0d", name, outs), 32'(m_data), exp_val);
                check_eq($sformatf("%s_last%0d", name, outs), 32'(m_last),
                         32'(outs == n_out - 1));
                outs++;
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check_eq({name, "_done_seen"}, 32'(finished), 32'd1);
        check_eq({name, "_out_count"}, 32'(outs), 32'(n_out));
        check_eq({name, "_pix_count"}, 32'(pix), 32'(n_pix));
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check_eq({name, "_busy_end"},  32'(busy), 32'd0);
        check_eq({name, "_sready_end"}, 32'(s_ready), 32'd0);
    endtask

    // Start with a bad config: expect error, no activity, no done.
    task automatic cfg_err(input string name, input int w, input int h, input int mode);
        int done_cnt;
        done_cnt = 0;
        do_start(w, h, mode);
        repeat (3) begin
            #1;
            if (done) done_cnt++;
            @(negedge clk);
        end
        #1;
        check_eq({name, "_error"},  32'(error),   32'd1);
        check_eq({name, "_busy"},   32'(busy),    32'd0);
        check_eq({name, "_sready"}, 32'(s_ready), 32'd0);
        check_eq({name, "_nodone"}, 32'(done_cnt), 32'd0);
    endtask

    initial begin
        int fed;
        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check_eq("reset_error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_frame("hramp",   5, 5, 2, 0, 1'b0, 1'b0, 32'h050);
        run_frame("vramp_gy", 5, 5, 1, 1, 1'b0, 1'b0, 32'h050);
        run_frame("vramp_gx", 5, 5, 0, 1, 1'b0, 1'b0, 32'h000);
        run_frame("neg_gx",  5, 5, 0, 2, 1'b0, 1'b0, 32'hFB0);
        run_frame("bp",      5, 5, 2, 0, 1'b1, 1'b1, 32'h050);
        run_frame("min3x3",  3, 3, 2, 0, 1'b0, 1'b0, 32'h050);
        run_frame("w4h3",    4, 3, 0, 0, 1'b1, 1'b0, 32'h050);

        cfg_err("err_w2",   2, 5, 2);
        cfg_err("err_wmax", MAX_WIDTH + 1, 5, 2);
        cfg_err("err_mode", 5, 5, 3);
        cfg_err("err_h2",   5, 2, 0);
        run_frame("clear_err", 5, 5, 2, 0, 1'b0, 1'b0, 32'h050);

        // Reset in the middle of a frame.
        do_start(5, 5, 2);
        fed = 0;
        for (int cyc = 0; cyc < 100 && fed < 12; cyc++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = pix_val(0, fed / 5, fed % 5);
            #1;
            if (s_ready) fed++;
        end
        check_eq("midrst_fed", 32'(fed), 32'd12);
        @(negedge clk);
        s_valid = 1'b0;
        check_eq("midrst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        check_eq("midrst_error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_rst", 5, 5, 2, 0, 1'b0, 1'b0, 32'h050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
